// File: rtl/usr_defs_pkg.sv
// Shared definitions for the universal register: operating mode codes.
// The testbench's reference model also uses these codes.
package usr_defs;

  localparam logic [2:0] MODO_HOLD = 3'b000;
  localparam logic [2:0] MODO_SHR  = 3'b001;
  localparam logic [2:0] MODO_SHL  = 3'b010;
  localparam logic [2:0] MODO_LOAD = 3'b011;
  localparam logic [2:0] MODO_ROTR = 3'b100;
  localparam logic [2:0] MODO_ROTL = 3'b101;
  localparam logic [2:0] MODO_INC  = 3'b110;
  localparam logic [2:0] MODO_DEC  = 3'b111;

endpackage

// File: rtl/usr_next_state.sv
// Combinational next-value logic for the universal register.
// It also flags a count that wraps around, either upward or downward.
module usr_next_state
  import usr_defs::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] i_an,
  input  logic [2:0]       i_modo,
  input  logic [WIDTH-1:0] i_in,
  input  logic             i_ser_der,
  input  logic             i_ser_izq,
  output logic [WIDTH-1:0] o_next,
  output logic             o_wrap
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  // Wrap is raised only by the two count modes. For an increment it marks
  // all-ones going to zero; for a decrement it marks zero going to all-ones.
  always_comb begin
    o_next = i_an;
    o_wrap = 1'b0;
    case (i_modo)
      MODO_HOLD: o_next = i_an;
      MODO_SHR:  o_next = {i_ser_der, i_an[WIDTH-1:1]};
      MODO_SHL:  o_next = {i_an[WIDTH-2:0], i_ser_izq};
      MODO_LOAD: o_next = i_in;
      MODO_ROTR: o_next = {i_an[0], i_an[WIDTH-1:1]};
      MODO_ROTL: o_next = {i_an[WIDTH-2:0], i_an[WIDTH-1]};
      MODO_INC: begin
        o_next = i_an + ONE;
        o_wrap = &i_an;
      end
      MODO_DEC: begin
        o_next = i_an - ONE;
        o_wrap = ~|i_an;
      end
      default: o_next = i_an;
    endcase
  end

endmodule

// File: rtl/universal_register_param.sv
// Parametrised universal register that can hold, shift, rotate, load and count.
// Provides serial outputs, a zero flag and a registered wrap pulse.
module universal_register_param
  import usr_defs::*;
#(
  parameter int          WIDTH       = 4,
  parameter logic [31:0] RESET_VALUE = 32'd0
) (
  input  logic             clk,
  input  logic             reset_sync,
  input  logic             en,
  input  logic [2:0]       modo,
  input  logic [WIDTH-1:0] In,
  input  logic             ser_der,
  input  logic             ser_izq,
  output logic [WIDTH-1:0] An,
  output logic             ser_out_der,
  output logic             ser_out_izq,
  output logic             cero,
  output logic             acarreo
);

  localparam logic [WIDTH-1:0] RST_VAL = RESET_VALUE[WIDTH-1:0];

  logic [WIDTH-1:0] r_an;
  logic             r_acarreo;
  logic [WIDTH-1:0] w_next;
  logic             w_wrap;

  usr_next_state #(.WIDTH(WIDTH)) u_next (
    .i_an      (r_an),
    .i_modo    (modo),
    .i_in      (In),
    .i_ser_der (ser_der),
    .i_ser_izq (ser_izq),
    .o_next    (w_next),
    .o_wrap    (w_wrap)
  );

  // Reset has priority over everything else. The wrap pulse lasts one cycle,
  // so it is cleared on every edge that is not itself a wrapping count.
  always_ff @(posedge clk) begin
    if (reset_sync) begin
      r_an      <= RST_VAL;
      r_acarreo <= 1'b0;
    end else if (en) begin
      r_an      <= w_next;
      r_acarreo <= w_wrap;
    end else begin
      r_acarreo <= 1'b0;
    end
  end

  assign An          = r_an;
  assign acarreo     = r_acarreo;
  assign ser_out_der = r_an[0];
  assign ser_out_izq = r_an[WIDTH-1];
  assign cero        = ~|r_an;

endmodule

// File: tb/tb_universal_register_param.sv
// Directed and randomised checks for universal_register_param.
// It uses two instances: the default 4-bit build and an 8-bit build with a nonzero reset value.
module tb_universal_register_param;
  import usr_defs::*;

  logic       clk = 1'b0;
  logic       resetSync;
  logic       en;
  logic [2:0] modo;
  logic [7:0] inData;
  logic       serDer;
  logic       serIzq;

  logic [3:0] an4;
  logic       serOutDer4, serOutIzq4, cero4, acarreo4;
  logic [7:0] an8;
  logic       serOutDer8, serOutIzq8, cero8, acarreo8;

  int errCount = 0;
  int checkCount = 0;

  always #5 clk = ~clk;

  universal_register_param #(.WIDTH(4), .RESET_VALUE(32'd0)) dut4 (
    .clk         (clk),
    .reset_sync  (resetSync),
    .en          (en),
    .modo        (modo),
    .In          (inData[3:0]),
    .ser_der     (serDer),
    .ser_izq     (serIzq),
    .An          (an4),
    .ser_out_der (serOutDer4),
    .ser_out_izq (serOutIzq4),
    .cero        (cero4),
    .acarreo     (acarreo4)
  );

  universal_register_param #(.WIDTH(8), .RESET_VALUE(32'hA5)) dut8 (
    .clk         (clk),
    .reset_sync  (resetSync),
    .en          (en),
    .modo        (modo),
    .In          (inData),
    .ser_der     (serDer),
    .ser_izq     (serIzq),
    .An          (an8),
    .ser_out_der (serOutDer8),
    .ser_out_izq (serOutIzq8),
    .cero        (cero8),
    .acarreo     (acarreo8)
  );

  // The inputs are driven 1 time unit after the rising edge. Each call returns
  // 1 time unit after the next rising edge, when the outputs are stable.
  task automatic applyStimulus(input logic rst, input logic e, input logic [2:0] m,
                               input logic [7:0] d, input logic sd, input logic si);
    resetSync = rst;
    en        = e;
    modo      = m;
    inData    = d;
    serDer    = sd;
    serIzq    = si;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  logic [7:0] mAn;
  logic       mAcarreo;
  logic       rRst, rEn, rSd, rSi;
  logic [2:0] rModo;
  logic [7:0] rIn;

  initial begin
    resetSync = 1'b0; en = 1'b0; modo = MODO_HOLD; inData = 8'h00;
    serDer = 1'b0; serIzq = 1'b0;
    #1;

    // Reset takes priority over en and modo.
    applyStimulus(1'b1, 1'b1, MODO_LOAD, 8'h0A, 1'b0, 1'b0);
    checkOutput("rst_an", 32'(an4), 32'h0);
    checkOutput("rst_acarreo", 32'(acarreo4), 32'h0);
    checkOutput("rst_cero", 32'(cero4), 32'h1);
    applyStimulus(1'b0, 1'b0, MODO_LOAD, 8'h0A, 1'b0, 1'b0);
    checkOutput("en0_hold", 32'(an4), 32'h0);

    // Load, then shift in both directions.
    applyStimulus(1'b0, 1'b1, MODO_LOAD, 8'h0B, 1'b0, 1'b0);
    checkOutput("load_1011", 32'(an4), 32'hB);
    applyStimulus(1'b0, 1'b1, MODO_SHR, 8'h00, 1'b0, 1'b0);
    checkOutput("shr_an", 32'(an4), 32'h5);
    checkOutput("shr_serout", 32'(serOutDer4), 32'h1);
    applyStimulus(1'b0, 1'b1, MODO_SHL, 8'h00, 1'b0, 1'b1);
    checkOutput("shl1_an", 32'(an4), 32'hB);
    applyStimulus(1'b0, 1'b1, MODO_SHL, 8'h00, 1'b0, 1'b0);
    checkOutput("shl0_an", 32'(an4), 32'h6);
    checkOutput("shl0_serout", 32'(serOutIzq4), 32'h0);

    // Rotate right once, then rotate left twice.
    applyStimulus(1'b0, 1'b1, MODO_LOAD, 8'h09, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, MODO_ROTR, 8'h00, 1'b0, 1'b0);
    checkOutput("rotr", 32'(an4), 32'hC);
    applyStimulus(1'b0, 1'b1, MODO_ROTL, 8'h00, 1'b0, 1'b0);
    checkOutput("rotl1", 32'(an4), 32'h9);
    applyStimulus(1'b0, 1'b1, MODO_ROTL, 8'h00, 1'b0, 1'b0);
    checkOutput("rotl2", 32'(an4), 32'h3);

    // Count up through the wrap from all-ones to zero.
    applyStimulus(1'b0, 1'b1, MODO_LOAD, 8'h0E, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, MODO_INC, 8'h00, 1'b0, 1'b0);
    checkOutput("inc_f_an", 32'(an4), 32'hF);
    checkOutput("inc_f_acarreo", 32'(acarreo4), 32'h0);
    applyStimulus(1'b0, 1'b1, MODO_INC, 8'h00, 1'b0, 1'b0);
    checkOutput("inc_wrap_an", 32'(an4), 32'h0);
    checkOutput("inc_wrap_acarreo", 32'(acarreo4), 32'h1);
    checkOutput("inc_wrap_cero", 32'(cero4), 32'h1);
    applyStimulus(1'b0, 1'b1, MODO_HOLD, 8'h00, 1'b0, 1'b0);
    checkOutput("hold_acarreo", 32'(acarreo4), 32'h0);

    // Count down through the wrap from zero to all-ones.
    applyStimulus(1'b0, 1'b1, MODO_DEC, 8'h00, 1'b0, 1'b0);
    checkOutput("dec_wrap_an", 32'(an4), 32'hF);
    checkOutput("dec_wrap_acarreo", 32'(acarreo4), 32'h1);
    applyStimulus(1'b0, 1'b1, MODO_DEC, 8'h00, 1'b0, 1'b0);
    checkOutput("dec_e_an", 32'(an4), 32'hE);
    checkOutput("dec_e_acarreo", 32'(acarreo4), 32'h0);

    // With en low, a count at all-ones neither moves An nor pulses acarreo.
    applyStimulus(1'b0, 1'b1, MODO_LOAD, 8'h0F, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, MODO_INC, 8'h00, 1'b0, 1'b0);
    checkOutput("en0_inc_an", 32'(an4), 32'hF);
    checkOutput("en0_inc_acarreo", 32'(acarreo4), 32'h0);

    // 8-bit build: reset value A5, count up three times, then reset in the middle of counting.
    applyStimulus(1'b1, 1'b0, MODO_HOLD, 8'h00, 1'b0, 1'b0);
    checkOutput("w8_rst_an", 32'(an8), 32'hA5);
    checkOutput("w8_rst_cero", 32'(cero8), 32'h0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, MODO_INC, 8'h00, 1'b0, 1'b0);
    checkOutput("w8_inc3", 32'(an8), 32'hA8);
    applyStimulus(1'b1, 1'b1, MODO_INC, 8'h00, 1'b0, 1'b0);
    checkOutput("w8_midrst_an", 32'(an8), 32'hA5);
    checkOutput("w8_midrst_acarreo", 32'(acarreo8), 32'h0);

    // Random operations compared against a behavioural model every cycle.
    mAn = 8'hA5;
    mAcarreo = 1'b0;
    for (int i = 0; i < 200; i++) begin
      rRst  = ($urandom_range(0, 31) == 0);
      rEn   = ($urandom_range(0, 3) != 0);
      rModo = 3'($urandom_range(0, 7));
      rIn   = 8'($urandom_range(0, 255));
      rSd   = 1'($urandom_range(0, 1));
      rSi   = 1'($urandom_range(0, 1));
      if (i % 40 == 5) begin
        rRst = 1'b0; rEn = 1'b1; rModo = MODO_LOAD; rIn = 8'hFE;
      end
      if (rRst) begin
        mAn = 8'hA5;
        mAcarreo = 1'b0;
      end else if (!rEn) begin
        mAcarreo = 1'b0;
      end else begin
        mAcarreo = 1'b0;
        case (rModo)
          MODO_SHR:  mAn = {rSd, mAn[7:1]};
          MODO_SHL:  mAn = {mAn[6:0], rSi};
          MODO_LOAD: mAn = rIn;
          MODO_ROTR: mAn = {mAn[0], mAn[7:1]};
          MODO_ROTL: mAn = {mAn[6:0], mAn[7]};
          MODO_INC: begin
            mAcarreo = (mAn == 8'hFF);
            mAn = mAn + 8'd1;
          end
          MODO_DEC: begin
            mAcarreo = (mAn == 8'h00);
            mAn = mAn - 8'd1;
          end
          default: mAn = mAn;
        endcase
      end
      applyStimulus(rRst, rEn, rModo, rIn, rSd, rSi);
      checkOutput("rnd_an", 32'(an8), 32'(mAn));
      checkOutput("rnd_acarreo", 32'(acarreo8), 32'(mAcarreo));
      checkOutput("rnd_cero", 32'(cero8), 32'(mAn == 8'h00));
      checkOutput("rnd_serout", 32'({serOutIzq8, serOutDer8}), 32'({mAn[7], mAn[0]}));
    end

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
